// File: rtl/lcd_pixel_fifo.sv
// lcd_pixel_fifo: first-word-fall-through 24-bit pixel buffer feeding the
// LCD pixel writer, with fill level, threshold flags and starvation stats.
module lcd_pixel_fifo #(
    parameter int DEPTH         = 64,
    parameter int AFULL_THRESH  = 48,
    parameter int AEMPTY_THRESH = 8
) (
    input  logic                       clk_12mhz,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [23:0]                wr_rgb,
    output logic                       full,
    output logic                       almost_full,
    output logic [23:0]                rgb,
    output logic                       data_valid,
    input  logic                       data_req,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     level,
    input  logic                       flush,
    input  logic                       clr_status,
    output logic                       overflow,
    output logic                       underflow,
    output logic [15:0]                underflow_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic [15:0]   underflow_count_q, underflow_count_d;

    logic pop_ok, push, pop, drop, starve;

    // Status decoded purely from the registered level.
    always_comb begin
        full         = (level_q == LW'(DEPTH));
        data_valid   = (level_q != '0);
        almost_full  = (level_q >= LW'(AFULL_THRESH));
        almost_empty = (level_q <= LW'(AEMPTY_THRESH));
        level        = level_q;
        rgb          = data_valid ? mem[rp_q] : 24'h0;
        overflow        = overflow_q;
        underflow       = underflow_q;
        underflow_count = underflow_count_q;
    end

    // Handshake events; flush suppresses the actual push/pop only.
    always_comb begin
        pop_ok = data_req & data_valid;
        starve = data_req & ~data_valid;
        drop   = wr_en & full & ~pop_ok;
        pop    = pop_ok & ~flush;
        push   = wr_en & (~full | pop_ok) & ~flush;
    end

    // Next-state for pointers, level and diagnostics.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        level_d = level_q;
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            level_d = '0;
        end else begin
            if (push) wp_d = wp_q + AW'(1);
            if (pop)  rp_d = rp_q + AW'(1);
            if (push && !pop)      level_d = level_q + LW'(1);
            else if (pop && !push) level_d = level_q - LW'(1);
        end

        if (clr_status) begin
            overflow_d        = drop;
            underflow_d       = starve;
            underflow_count_d = starve ? 16'd1 : 16'd0;
        end else begin
            overflow_d        = overflow_q | drop;
            underflow_d       = underflow_q | starve;
            underflow_count_d = underflow_count_q;
            if (starve && underflow_count_q != CNT_MAX)
                underflow_count_d = underflow_count_q + 16'd1;
        end
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge clk_12mhz or posedge rst) begin
        if (rst) begin
            wp_q              <= '0;
            rp_q              <= '0;
            level_q           <= '0;
            overflow_q        <= 1'b0;
            underflow_q       <= 1'b0;
            underflow_count_q <= '0;
        end else begin
            wp_q              <= wp_d;
            rp_q              <= rp_d;
            level_q           <= level_d;
            overflow_q        <= overflow_d;
            underflow_q       <= underflow_d;
            underflow_count_q <= underflow_count_d;
        end
    end

    // Pixel storage; contents are don't-care after reset.
    always_ff @(posedge clk_12mhz) begin
        if (push) mem[wp_q] <= wr_rgb;
    end

endmodule

// File: doc/lcd_pixel_fifo.md
# lcd_pixel_fifo

Pixel buffer that sits directly upstream of the LCD pixel writer. It absorbs bursty 24-bit RGB writes from the render/framebuffer side and presents them first-word-fall-through to the writer's `rgb`/`data_valid`/`data_req` handshake. It also reports fill level, threshold flags and underflow/overflow diagnostics, so firmware can size prefetch and detect starved lines.

## Interface
Parameters:
- `DEPTH`, default 64: number of 24-bit entries. Must be a power of two and ≥ 4.
- `AFULL_THRESH`, default 48: `almost_full` asserts when `level` ≥ this value.
- `AEMPTY_THRESH`, default 8: `almost_empty` asserts when `level` ≤ this value.

Ports (clock and reset first). The block has one clock. Reset is asynchronous and active-high.
- `clk_12mhz`  in  1  pixel/system clock; all logic is clocked on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe from the producer.
- `wr_rgb`  in  24  pixel to write, {R[23:16], G[15:8], B[7:0]}.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `almost_full`  out  1  `level` ≥ `AFULL_THRESH`.
- `rgb`  out  24  head-of-FIFO pixel; 24'h000000 when `data_valid` is 0.
- `data_valid`  out  1  FIFO not empty.
- `data_req`  in  1  pop request from the pixel writer.
- `almost_empty`  out  1  `level` ≤ `AEMPTY_THRESH`.
- `level`  out  $clog2(DEPTH)+1  current entry count.
- `flush`  in  1  synchronous clear of contents.
- `clr_status`  in  1  synchronous clear of the sticky flags and the counter.
- `overflow`  out  1  sticky: a write was dropped.
- `underflow`  out  1  sticky: a request arrived while empty.
- `underflow_count`  out  16  saturating count of starved requests.

## Operation
- Storage is a `DEPTH`×24 register array, with write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits. Both pointers wrap modulo `DEPTH`. `level` is kept as a separate counter.
- Push occurs when `wr_en` is 1 and either (`full` is 0) or (`full` is 1 and a pop occurs in the same cycle). On push, `mem[wp] <= wr_rgb` and `wp++`.
- Dropped write: `wr_en` is 1, `full` is 1 and there is no pop. The data is discarded and `overflow` is set.
- Pop occurs when `data_req` is 1 and `data_valid` is 1 (both sampled at the edge). On pop, `rp++`.
- Starved request: `data_req` is 1 and `data_valid` is 0. Set `underflow` and increment `underflow_count`, saturating at 16'hFFFF.
- Push and pop while empty: the pop is not performed. The push is accepted and the starved request is counted.
- Push and pop while non-empty: `level` is unchanged and both pointers advance.
- `rgb = data_valid ? mem[rp] : 24'h0`. This is combinational from registered state.
- `full`, `data_valid`, `almost_full` and `almost_empty` are decoded from the registered `level`.
- `flush` sets `wp`, `rp` and `level` to 0. Any push or pop in the same cycle is ignored. Sticky flags and `underflow_count` are unaffected.
- `clr_status` clears `overflow`, `underflow` and `underflow_count`. If a new event occurs in the same cycle, that event wins: the flag is set and the count becomes 1.
- Priority order is `rst` > `flush` > normal operation. `clr_status` operates independently of `flush`.

## Timing
- Reset (asynchronous, any time, including mid-burst) forces the following; array contents need not be cleared.
  - `wp = rp = level = 0`
  - `data_valid = 0`, `rgb = 0`, `full = 0`
  - `almost_empty = 1`, `almost_full = 0`
  - `overflow = underflow = 0`, `underflow_count = 0`
- Write latency: a push at edge N makes `data_valid` and `rgb` reflect the pixel after edge N, so the writer can consume it at edge N+1.
- Pop latency: a pop at edge N presents the next entry, or `data_valid = 0`, after edge N. The writer can therefore pop on every consecutive cycle at full rate.
- `level` updates on the same edge as the push/pop and always stays in the range 0..`DEPTH`.
- The threshold flags and `full` change on the same edge as `level`.

## Test plan
- Reset, then write 24'h112233, 24'h445566, 24'h778899 with `data_req` = 0 → `level` = 3 and `rgb` = 24'h112233. Then hold `data_req` for 3 cycles → `rgb` sequence 112233, 445566, 778899, after which `data_valid` = 0, `rgb` = 0 and `underflow` = 0.
- Fill to `DEPTH` = 64 with an incrementing pattern → `full` = 1. A further write of 24'hDEAD00 → `overflow` = 1, `level` = 64. Drain all 64 → the pattern reads back in order and the dropped value never appears.
- At `full`, assert `wr_en` and `data_req` for 100 cycles → `level` stays 64, `overflow` stays 0, and the output order is preserved across wrap-around of `wp`/`rp`.
- Empty FIFO, `data_req` held for 5 cycles → `underflow` = 1, `underflow_count` = 5. Pulse `clr_status` → both return to 0. Preload `underflow_count` = 16'hFFFF by forcing and request again → the count stays at FFFF.
- Level = 10, then pulse `flush` while `wr_en` = 1 → `level` = 0, `data_valid` = 0, and the next write is the first word out.
- Assert `rst` mid-burst at level = 20 → all outputs take their reset values immediately, without waiting for a clock edge. Level sweep 0→64→0 → `almost_full` asserts at 48 and `almost_empty` deasserts at 9.
